// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_pkg
// Description : Shared definitions for the bit-serial adder controller:
//               FSM state encoding, default operand width and the
//               majority (carry) helper used by the 1-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

    // Default operand/sum width of the serial adder datapath.
    localparam int c_DEFAULT_N = 8;

    // Controller states, 2-bit encoding shared with the adder top level.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Carry generation of a full adder: true when at least two inputs are set.
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Combinational 1-bit full adder (sum and carry).
// Ports       : i_a, i_b - addend bits
//               i_c      - carry in
//               o_s      - sum bit
//               o_co     - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import serial_add_ctrl_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = majority(i_a, i_b, i_c);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Controller/consumer for a bit-serial adder. Strobes the
//               shared load of two upstream PISO shift registers, adds their
//               LSB-first serial outputs for N clocks with a registered carry
//               and assembles the N-bit sum plus carry-out.
// Ports       : clk   - system clock (rising edge)
//               rst   - asynchronous active-high reset
//               start - begin an addition (sampled only in IDLE)
//               cin   - carry-in, captured when start is accepted
//               a_bit - serial operand A (LSB first)
//               b_bit - serial operand B (LSB first)
//               load  - load strobe to both shift registers
//               busy  - high in every state except IDLE
//               done  - one-cycle pulse, sum/cout valid
//               sum   - parallel sum, held until the next accepted start
//               cout  - final carry-out, held with sum
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int N     = c_DEFAULT_N,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin,
    input  logic         a_bit,
    input  logic         b_bit,
    output logic         load,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Count value seen on the edge that consumes the last (MSB) bit.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;
    logic [N-1:0]       r_sum;
    logic               r_cout;
    logic               w_s;
    logic               w_co;

    full_adder u_full_adder (
        .i_a  (a_bit),
        .i_b  (b_bit),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        load         = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load         = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_count == c_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: bit counter, carry, sum shift register, carry-out
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_carry <= cin;
                        r_count <= '0;
                        r_sum   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // New bit enters at the MSB; after N shifts bit 0 has
                    // walked down to sum[0].
                    r_carry <= w_co;
                    r_sum   <= {w_s, r_sum[N-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == c_LAST) begin
                        r_cout <= w_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_add_ctrl
`default_nettype wire
